// File: rtl/heat_profile_seq.sv
// Steps the heater setpoint code through a ramp/soak profile with optional cool-down (HEAT_PROFILE_COOL_EN).
// Latency: outputs registered, temp_i decisions take sample + transition edge; no backpressure, abort_i always wins.
module heat_profile_seq #(
    parameter int unsigned TICK_DIV      = 100_000_000,
    parameter int unsigned NUM_STEPS     = 5,
    parameter logic [14:0] PROFILE_CASES = 15'o54321,
    parameter logic [39:0] PROFILE_DWELL = 40'h0A_0A_0A_0A_0A,
    parameter int unsigned RAMP_TIMEOUT  = 600,
    parameter int unsigned TOL           = 2,
    parameter logic [7:0]  COOL_TEMP     = 8'h32
) (
    input  logic       clk_i,
    input  logic       rst,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] temp_i,
    output logic [2:0] tempCase_o,
    output logic [2:0] step_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       fault_o
);

    localparam int unsigned PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
    localparam logic [2:0] LAST_STEP  = 3'(NUM_STEPS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RAMP  = 3'd1,
        S_SOAK  = 3'd2,
        S_DONE  = 3'd3,
        S_FAULT = 3'd4
`ifdef HEAT_PROFILE_COOL_EN
        , S_COOL = 3'd5
`endif
    } state_t;

    function automatic logic [2:0] code_of(input logic [2:0] k);
        return PROFILE_CASES[3*k +: 3];
    endfunction

    function automatic logic [7:0] dwell_of(input logic [2:0] k);
        return PROFILE_DWELL[8*k +: 8];
    endfunction

    function automatic logic [7:0] setpoint(input logic [2:0] c);
        case (c)
            3'd1:    return 8'h28;
            3'd2:    return 8'h46;
            3'd3:    return 8'h64;
            3'd4:    return 8'h7F;
            3'd5:    return 8'h96;
            default: return 8'hFF;
        endcase
    endfunction

    logic [7:0]    r_temp_q;
    state_t        r_state;
    logic [2:0]    r_step;
    logic [PW-1:0] r_presc;
    logic [7:0]    r_dwell;
    logic [15:0]   r_ramp_tmr;

    state_t        w_nxt_state;
    logic [2:0]    w_nxt_step;
    logic [2:0]    w_code;
    logic          w_tick;
    logic [15:0]   w_tmr_nxt;
    logic          w_reached;
    logic          w_timeout;
    logic          w_expired;
    logic          w_enter;
    logic          w_nxt_busy;

    assign w_code    = code_of(r_step);
    assign w_tick    = (r_presc == TICK_LAST);
    assign w_tmr_nxt = (w_tick && r_ramp_tmr != 16'hFFFF) ? r_ramp_tmr + 16'd1 : r_ramp_tmr;
    assign w_reached = ({1'b0, r_temp_q} + 9'(TOL)) >= {1'b0, setpoint(w_code)};
    assign w_timeout = (RAMP_TIMEOUT != 0) && ({16'd0, w_tmr_nxt} >= RAMP_TIMEOUT);
    // Expiry fires on the tick that would take the counter to zero so SOAK lasts exactly D ticks.
    assign w_expired = (r_dwell == 8'd0) || (w_tick && r_dwell == 8'd1);
    assign w_enter   = (w_nxt_state != r_state);

`ifdef HEAT_PROFILE_COOL_EN
    logic w_cooled;
    assign w_cooled   = (r_temp_q <= COOL_TEMP);
    assign w_nxt_busy = (w_nxt_state == S_RAMP) || (w_nxt_state == S_SOAK) || (w_nxt_state == S_COOL);
`else
    assign w_nxt_busy = (w_nxt_state == S_RAMP) || (w_nxt_state == S_SOAK);
`endif

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_step  = r_step;
        if (abort_i) begin
            w_nxt_state = S_IDLE;
            w_nxt_step  = 3'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        w_nxt_state = S_RAMP;
                        w_nxt_step  = 3'd0;
                    end
                end
                S_RAMP: begin
                    // Reached beats timeout when both land in the same cycle.
                    if (w_code >= 3'd6)                   w_nxt_state = S_FAULT;
                    else if (w_code == 3'd0 || w_reached) w_nxt_state = S_SOAK;
                    else if (w_timeout)                   w_nxt_state = S_FAULT;
                end
                S_SOAK: begin
                    if (w_expired) begin
                        if (r_step < LAST_STEP) begin
                            w_nxt_state = S_RAMP;
                            w_nxt_step  = r_step + 3'd1;
                        end else begin
`ifdef HEAT_PROFILE_COOL_EN
                            w_nxt_state = S_COOL;
`else
                            w_nxt_state = S_DONE;
`endif
                        end
                    end
                end
`ifdef HEAT_PROFILE_COOL_EN
                S_COOL: if (w_cooled) w_nxt_state = S_DONE;
`endif
                S_FAULT: w_nxt_state = S_FAULT;
                default: w_nxt_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            r_temp_q   <= 8'd0;
            r_state    <= S_IDLE;
            r_step     <= 3'd0;
            r_presc    <= '0;
            r_dwell    <= 8'd0;
            r_ramp_tmr <= 16'd0;
            tempCase_o <= 3'd0;
            step_o     <= 3'd0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            fault_o    <= 1'b0;
        end else begin
            r_temp_q <= temp_i;
            r_state  <= w_nxt_state;
            r_step   <= w_nxt_step;
            r_presc  <= (w_enter || w_tick) ? '0 : r_presc + 1'b1;

            if (w_enter && w_nxt_state == S_SOAK)
                r_dwell <= dwell_of(w_nxt_step);
            else if (r_state == S_SOAK && w_tick && r_dwell != 8'd0)
                r_dwell <= r_dwell - 8'd1;

            if (w_enter && w_nxt_state == S_RAMP)
                r_ramp_tmr <= 16'd0;
            else if (r_state == S_RAMP)
                r_ramp_tmr <= w_tmr_nxt;

            tempCase_o <= (w_nxt_state == S_RAMP || w_nxt_state == S_SOAK) ? code_of(w_nxt_step) : 3'd0;
            step_o     <= w_nxt_step;
            busy_o     <= w_nxt_busy;
            done_o     <= (w_nxt_state == S_DONE);
            fault_o    <= (w_nxt_state == S_FAULT);
        end
    end

endmodule

// File: tb/tb_heat_profile_seq.sv
// Bench for heat_profile_seq: two profiles sharing one stimulus stream, checked each cycle
// against a cycle-count model of the profile rules plus hand-computed literal checkpoints.
module tb_heat_profile_seq;

    localparam int TDIV = 10;
`ifdef HEAT_PROFILE_COOL_EN
    localparam bit COOL_EN = 1'b1;
`else
    localparam bit COOL_EN = 1'b0;
`endif

    // Profile A: codes {1,3,0}, dwell {3,2,2}, timeout 4 ticks. Profile B: codes {1,6}, dwell 0, no timeout.
    localparam logic [14:0] A_CASES = 15'o00031;
    localparam logic [39:0] A_DWELL = 40'h00_00_02_02_03;
    localparam logic [14:0] B_CASES = 15'o00061;
    localparam logic [39:0] B_DWELL = 40'h00_00_00_00_00;

    localparam int M_IDLE = 0, M_RAMP = 1, M_SOAK = 2, M_COOL = 3, M_DONE = 4, M_FAULT = 5;

    logic       clk_i = 1'b0;
    logic       rst = 1'b1;
    logic       start_i = 1'b0;
    logic       abort_i = 1'b0;
    logic [7:0] temp_i = 8'd20;

    logic [2:0] a_tc, a_step, b_tc, b_step;
    logic       a_busy, a_done, a_fault, b_busy, b_done, b_fault;

    int total = 0;
    int bad = 0;

    always #5 clk_i = ~clk_i;

    heat_profile_seq #(
        .TICK_DIV(TDIV), .NUM_STEPS(3), .PROFILE_CASES(A_CASES), .PROFILE_DWELL(A_DWELL),
        .RAMP_TIMEOUT(4), .TOL(2), .COOL_TEMP(8'h32)
    ) u_a (
        .clk_i(clk_i), .rst(rst), .start_i(start_i), .abort_i(abort_i), .temp_i(temp_i),
        .tempCase_o(a_tc), .step_o(a_step), .busy_o(a_busy), .done_o(a_done), .fault_o(a_fault)
    );

    heat_profile_seq #(
        .TICK_DIV(TDIV), .NUM_STEPS(2), .PROFILE_CASES(B_CASES), .PROFILE_DWELL(B_DWELL),
        .RAMP_TIMEOUT(0), .TOL(2), .COOL_TEMP(8'h32)
    ) u_b (
        .clk_i(clk_i), .rst(rst), .start_i(start_i), .abort_i(abort_i), .temp_i(temp_i),
        .tempCase_o(b_tc), .step_o(b_step), .busy_o(b_busy), .done_o(b_done), .fault_o(b_fault)
    );

    function automatic int code_of(int d, int k);
        logic [14:0] v;
        v = (d == 0) ? A_CASES : B_CASES;
        return int'(v[3*k +: 3]);
    endfunction

    function automatic int dwell_of(int d, int k);
        logic [39:0] v;
        v = (d == 0) ? A_DWELL : B_DWELL;
        return int'(v[8*k +: 8]);
    endfunction

    function automatic int sp_of(int c);
        case (c)
            1: return 40;
            2: return 70;
            3: return 100;
            4: return 127;
            5: return 150;
            default: return 1000;
        endcase
    endfunction

    // Model: state, step, cycles spent in the current state, last sampled temperature.
    int m_st[2], m_step[2], m_cyc[2], m_tq[2];
    int m_nsteps[2] = '{3, 2};
    int m_rt[2]     = '{4, 0};

    always @(posedge clk_i or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                m_st[d] = M_IDLE; m_step[d] = 0; m_cyc[d] = 0; m_tq[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int ns, nk, c, dur;
                ns = m_st[d];
                nk = m_step[d];
                c  = code_of(d, m_step[d]);
                if (abort_i) begin
                    ns = M_IDLE; nk = 0;
                end else begin
                    case (m_st[d])
                        M_IDLE, M_DONE: if (start_i) begin ns = M_RAMP; nk = 0; end
                        M_RAMP: begin
                            if (c >= 6) ns = M_FAULT;
                            else if (c == 0 || m_tq[d] + 2 >= sp_of(c)) ns = M_SOAK;
                            else if (m_rt[d] != 0 && m_cyc[d] + 1 >= m_rt[d] * TDIV) ns = M_FAULT;
                        end
                        M_SOAK: begin
                            dur = (dwell_of(d, m_step[d]) == 0) ? 1 : dwell_of(d, m_step[d]) * TDIV;
                            if (m_cyc[d] + 1 >= dur) begin
                                if (m_step[d] < m_nsteps[d] - 1) begin ns = M_RAMP; nk = m_step[d] + 1; end
                                else ns = COOL_EN ? M_COOL : M_DONE;
                            end
                        end
                        M_COOL: if (m_tq[d] <= 50) ns = M_DONE;
                        default: ;
                    endcase
                end
                m_cyc[d]  = (ns != m_st[d]) ? 0 : m_cyc[d] + 1;
                m_st[d]   = ns;
                m_step[d] = nk;
                m_tq[d]   = int'(temp_i);
            end
        end
    end

    function automatic logic [8:0] exp_out(int d);
        logic [2:0] tc;
        logic       busy;
        tc   = (m_st[d] == M_RAMP || m_st[d] == M_SOAK) ? 3'(code_of(d, m_step[d])) : 3'd0;
        busy = (m_st[d] == M_RAMP || m_st[d] == M_SOAK || m_st[d] == M_COOL);
        return {tc, 3'(m_step[d]), busy, m_st[d] == M_DONE, m_st[d] == M_FAULT};
    endfunction

    always @(negedge clk_i) begin
        for (int d = 0; d < 2; d++) begin
            logic [8:0] act, exp;
            act = (d == 0) ? {a_tc, a_step, a_busy, a_done, a_fault}
                           : {b_tc, b_step, b_busy, b_done, b_fault};
            exp = exp_out(d);
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL model_cmp dut%0d t=%0t {tc,step,busy,done,fault} got=%b want=%b",
                         d, $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, act, exp);
        end
    endtask

    task automatic wn(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    initial begin
        wn(2);
        chk("rst_tc", a_tc, 0);
        chk("rst_step", a_step, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_flags", {a_done, a_fault, b_fault}, 0);
        rst = 1'b0;
        wn(2);

        // Nominal run with tolerance boundary on step 1 and zero code on step 2.
        start_i = 1'b1;
        wn(1); start_i = 1'b0;
        chk("start_tc", a_tc, 1);
        chk("start_busy", a_busy, 1);
        wn(5); temp_i = 8'd30;
        wn(3); temp_i = 8'd99;
        wn(2); temp_i = 8'h61;
        wn(29);
        chk("soak0_end_step", a_step, 0);
        wn(1);
        chk("soak0_next_step", a_step, 1);
        chk("soak0_next_tc", a_tc, 3);
        chk("b_illegal_fault", b_fault, 1);
        wn(10);
        chk("tol_hold_step", a_step, 1);
        temp_i = 8'h62;
        wn(21);
        chk("soak1_end_step", a_step, 1);
        wn(1);
        chk("zero_code_step", a_step, 2);
        chk("zero_code_tc", a_tc, 0);
        temp_i = 8'd150;
        wn(10);
        chk("zero_soak_busy", a_busy, 1);
        chk("zero_soak_tc", a_tc, 0);
        wn(11);
        chk("last_soak_busy", a_busy, COOL_EN ? 1 : 0);
        chk("last_soak_done", a_done, COOL_EN ? 0 : 1);
        temp_i = 8'h33;
        wn(5);
        chk("cool_above_done", a_done, COOL_EN ? 0 : 1);
        temp_i = 8'h32;
        wn(2);
        chk("cool_exit_done", a_done, 1);
        chk("cool_exit_busy", a_busy, 0);

        // Ramp timeout restarted from DONE; B stays in FAULT and ignores start.
        temp_i = 8'd20; start_i = 1'b1;
        wn(1); start_i = 1'b0;
        chk("restart_tc", a_tc, 1);
        wn(39);
        chk("timeout_early", a_fault, 0);
        wn(1);
        chk("timeout_fault", a_fault, 1);
        chk("timeout_tc", a_tc, 0);
        start_i = 1'b1;
        wn(1); start_i = 1'b0;
        wn(1);
        chk("fault_ignores_start", a_fault, 1);
        abort_i = 1'b1;
        wn(1); abort_i = 1'b0;
        chk("abort_fault_clr", a_fault, 0);
        chk("abort_b_fault_clr", b_fault, 0);

        // Abort together with start on the dwell-expiry cycle of step 0.
        temp_i = 8'd99; start_i = 1'b1;
        wn(1); start_i = 1'b0;
        wn(30);
        chk("pre_abort_busy", a_busy, 1);
        abort_i = 1'b1; start_i = 1'b1;
        wn(1); abort_i = 1'b0; start_i = 1'b0;
        chk("abort_tc", a_tc, 0);
        chk("abort_step", a_step, 0);
        chk("abort_busy", a_busy, 0);
        wn(1);
        chk("abort_stays_idle", a_busy, 0);

        // Asynchronous reset between edges while A soaks and B sits in FAULT.
        start_i = 1'b1;
        wn(1); start_i = 1'b0;
        wn(10);
        chk("pre_rst_busy", a_busy, 1);
        chk("pre_rst_b_fault", b_fault, 1);
        @(posedge clk_i);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_tc", a_tc, 0);
        chk("async_rst_busy", a_busy, 0);
        chk("async_rst_b_fault", b_fault, 0);
        @(negedge clk_i);
        rst = 1'b0;
        wn(3);
        chk("post_rst_idle", {a_busy, a_done, a_fault}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
